parity_rr_scheduler: RTL and testbench

- Shares one serial odd-parity engine between N_REQ requesters using round-robin arbitration.
- A granted requester's word is loaded into a shift register. Its bits pass one per cycle through a single-bit XOR accumulator seeded for odd parity.
- The result is returned with the requester's ID.
- Sits between the multi-channel data sources and the parity-check/generation path. It replaces per-channel combinational parity logic when area matters more than latency.

---
 rtl/parity_rr_scheduler_pkg.sv | 18 +
 rtl/parity_rr_scheduler_rr_arbiter.sv | 46 ++++
 rtl/parity_rr_scheduler.sv | 127 ++++++++++++
 tb/tb_parity_rr_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/parity_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin serial odd-parity scheduler.
// Holds the FSM state encoding, the accumulator seed and the ID width derivation.
package parity_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic ODD_SEED = 1'b1;

    // A single requester still needs a 1-bit ID port.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parity_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by the pointer,
// priority-encode the lowest set bit, then rotate the winner back.
module rr_arbiter
    import parity_rr_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned ID_W = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  pointer,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  index
);

    logic [N_REQ-1:0] rotated;
    logic             found;
    int unsigned      offset;
    int unsigned      winner;

    always_comb begin
        rotated = '0;
        found   = 1'b0;
        offset  = 0;
        winner  = 0;
        grant   = '0;
        index   = '0;

        for (int unsigned k = 0; k < N_REQ; k++) begin
            rotated[k] = req[(k + int'(pointer)) % N_REQ];
        end

        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && rotated[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end

        winner = (offset + int'(pointer)) % N_REQ;
        if (found) begin
            grant = N_REQ'(1) << winner;
            index = ID_W'(winner);
        end
    end

endmodule

// File: rtl/parity_rr_scheduler.sv
// Shares one serial odd-parity engine between N_REQ requesters: round-robin grant,
// bit-serial XOR accumulation seeded with 1, result returned with the requester ID.
module parity_rr_scheduler
    import parity_rr_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic                      res_par
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   ptr;
    logic [N_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]   arb_index;
    logic [DATA_W-1:0] sel_word;
    logic              start;
    logic              last_bit;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arbiter (
        .req     (req),
        .pointer (ptr),
        .grant   (arb_grant),
        .index   (arb_index)
    );

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_index == ID_W'(i)) begin
                sel_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign last_bit = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    start      = 1'b1;
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // busy is only re-evaluated in IDLE, so it stays high through the result cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_par   <= 1'b0;
            sr        <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            id        <= '0;
            ptr       <= '0;
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        gnt <= arb_grant;
                        sr  <= sel_word;
                        acc <= ODD_SEED;
                        cnt <= '0;
                        id  <= arb_index;
                    end
                end
                S_SHIFT: begin
                    acc <= acc ^ sr[0];
                    sr  <= sr >> 1;
                    cnt <= cnt + CNT_W'(1);
                end
                S_DONE: begin
                    res_valid <= 1'b1;
                    res_par   <= acc;
                    res_id    <= id;
                    ptr       <= (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_rr_scheduler.sv
// Randomized bench for parity_rr_scheduler: a timeline-based reference model
// predicts grants, busy windows and parity results cycle by cycle.
module tb_parity_rr_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] gnt;
    logic         busy;
    logic         res_valid;
    logic [1:0]   res_id;
    logic         res_par;

    parity_rr_scheduler #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_par   (res_par)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: a job granted in cycle g occupies g..g+W+1, result in g+W+1
    int cyc     = 0;
    int free_at = 0;
    int gnt_cyc = -100;
    int ptr_m   = 0;
    int pend_id = 0;
    int held_id = 0;
    logic pend_par = 1'b0;
    logic held_par = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d);
        logic [N-1:0] exp_gnt;
        logic [W-1:0] word;
        logic         exp_busy;
        logic         exp_valid;
        int           cand;
        req      = r;
        req_data = d;
        cyc++;
        exp_gnt = '0;
        if (cyc >= free_at && r != 0) begin
            cand = -1;
            for (int k = 0; k < N; k++) begin
                if (cand < 0 && r[(ptr_m + k) % N]) cand = (ptr_m + k) % N;
            end
            exp_gnt  = N'(1) << cand;
            word     = d[cand*W +: W];
            pend_par = ~^word;
            pend_id  = cand;
            gnt_cyc  = cyc;
            free_at  = cyc + W + 2;
            ptr_m    = (cand + 1) % N;
        end
        exp_busy  = (cyc >= gnt_cyc) && (cyc <= gnt_cyc + W + 1);
        exp_valid = (cyc == gnt_cyc + W + 1);
        if (exp_valid) begin
            held_id  = pend_id;
            held_par = pend_par;
        end
        @(posedge clk);
        #1;
        check("gnt", 64'(gnt), 64'(exp_gnt));
        check("busy", 64'(busy), 64'(exp_busy));
        check("res_valid", 64'(res_valid), 64'(exp_valid));
        check("res_id", 64'(res_id), 64'(held_id));
        check("res_par", 64'(res_par), 64'(held_par));
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        #1;
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(res_valid), 64'(0));
        check("rst_id", 64'(res_id), 64'(0));
        check("rst_par", 64'(res_par), 64'(0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cyc++;
        free_at  = 0;
        gnt_cyc  = -100;
        ptr_m    = 0;
        held_id  = 0;
        held_par = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0);
    endtask

    logic [N*W-1:0] hold_d;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single requester 2, zero word
        step(4'b0100, '0);
        idle(11);

        // requester 0 continuously, words 07, FF, 80
        step(4'b0001, 32'h07);
        for (int i = 0; i < 9; i++) step(4'b0001, 32'hFF);
        step(4'b0001, 32'hFF);
        for (int i = 0; i < 9; i++) step(4'b0001, 32'h80);
        step(4'b0001, 32'h80);
        idle(11);

        // all requesters from reset
        do_reset();
        for (int i = 0; i < 60; i++) step(4'hF, $urandom);

        // pointer wrap after a job for requester 1
        do_reset();
        step(4'b0010, $urandom);
        idle(9);
        for (int i = 0; i < 22; i++) step(4'b1010, $urandom);
        idle(11);

        // reset during SHIFT drops the job
        step(4'b0100, $urandom);
        idle(3);
        do_reset();
        step(4'b0110, $urandom);
        idle(11);

        // req0 raised while requester 2 is busy
        do_reset();
        step(4'b0100, $urandom);
        idle(2);
        hold_d = $urandom;
        for (int i = 0; i < 8; i++) step(4'b0001, hold_d);
        for (int i = 0; i < 12; i++) step(4'b0000, $urandom);

        // random traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else if ($urandom_range(0, 3) == 0) step('0, $urandom);
            else step(N'($urandom_range(0, 15)), $urandom);
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
